// File: rtl/input_act_stream.sv
// Activation feeder: a show-ahead word FIFO whose head word is sliced into
// LANES-wide beats and streamed out under a START/LEN handshake.
module input_act_stream #(
    parameter int unsigned IN_W    = 32,
    parameter int unsigned SLICE_W = 8,
    parameter int unsigned LANES   = 2,
    parameter int unsigned DEPTH   = 64
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic                          CLEAR,
    input  logic                          WR_EN,
    input  logic [IN_W-1:0]               WR_DATA,
    output logic                          FULL,
    output logic                          EMPTY,
    output logic [$clog2(DEPTH):0]        LEVEL,
    input  logic                          START,
    input  logic [15:0]                   LEN,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [SLICE_W*LANES-1:0]      OUT_DATA,
    output logic                          OUT_LAST
);

    localparam int unsigned BEAT_W = SLICE_W * LANES;
    localparam int unsigned BEATS  = IN_W / BEAT_W;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned BIW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [AW:0]    FULL_LVL  = (AW + 1)'(DEPTH);
    localparam logic [BIW-1:0] LAST_BEAT = BIW'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StFeed, StFin} state_e;

    logic [IN_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;

    state_e          state_q;
    logic [BIW-1:0]  beat_q;
    logic [15:0]     rem_q;
    logic            done_q;

    logic            feeding;
    logic            xfer;
    logic            pop;
    logic            push;
    logic [IN_W-1:0] head;

    always_comb begin
        EMPTY     = (count_q == '0);
        FULL      = (count_q == FULL_LVL);
        LEVEL     = count_q;
        feeding   = (state_q == StFeed);
        OUT_VALID = feeding && !EMPTY;
        OUT_LAST  = OUT_VALID && (rem_q == 16'd1);
        xfer      = OUT_VALID && OUT_READY;
        // The last beat of a feed pops its word even if it is only partly consumed.
        pop       = xfer && ((beat_q == LAST_BEAT) || (rem_q == 16'd1));
        push      = WR_EN && (!FULL || pop);
        head      = mem_q[rd_ptr_q];
        OUT_DATA  = head[int'(beat_q) * BEAT_W +: BEAT_W];
        BUSY      = (state_q != StIdle);
        DONE      = done_q;
    end

    always_ff @(posedge CLK) begin
        if (RESETN && !CLEAR && push) begin
            mem_q[wr_ptr_q] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN || CLEAR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN || CLEAR) begin
            state_q <= StIdle;
            beat_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (START && (LEN != 16'd0)) begin
                        state_q <= StFeed;
                        rem_q   <= LEN;
                        beat_q  <= '0;
                    end
                end
                StFeed: begin
                    if (xfer) begin
                        rem_q  <= rem_q - 16'd1;
                        beat_q <= pop ? '0 : beat_q + 1'b1;
                        if (rem_q == 16'd1) begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_act_stream.sv
// Bench for input_act_stream: vector table for the basic feed, scoreboarded beats
// checked on the falling edge, and hand sequences for stall, full and clear cases.
module tb_input_act_stream;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic        empty;
    logic [6:0]  level;
    logic        start;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    always #5 clk = ~clk;

    input_act_stream #(
        .IN_W    (32),
        .SLICE_W (8),
        .LANES   (2),
        .DEPTH   (64)
    ) dut (
        .CLK       (clk),
        .RESETN    (resetn),
        .CLEAR     (clear),
        .WR_EN     (wr_en),
        .WR_DATA   (wr_data),
        .FULL      (full),
        .EMPTY     (empty),
        .LEVEL     (level),
        .START     (start),
        .LEN       (len),
        .BUSY      (busy),
        .DONE      (done),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data),
        .OUT_LAST  (out_last)
    );

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        st;
        logic [15:0] len;
        logic        rdy;
        int          nbeats;
        int          last_on;
        logic [6:0]  e_level;
        logic        e_empty;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;

    vec_t        vecs [8];
    beat_t       exp_q [$];
    beat_t       e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the beats a word is expected to yield; last_on = 1-based index of the LAST beat.
    task automatic push_word(input logic [31:0] data, input int nb, input int last_on);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.data = data[16*k +: 16];
            b.last = (last_on == k + 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic write_word(input logic [31:0] data);
        wr_en   = 1'b1;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int k = 0; k < budget && !done; k++) begin
            tick();
        end
        check(name, done, 1);
    endtask

    function automatic logic [31:0] wd(input int i);
        return {16'(i) + 16'h1000, 16'(i) ^ 16'hBEEF};
    endfunction

    // Transfers are decided by values settled before the next rising edge.
    always @(negedge clk) begin
        if (out_valid && prev_stall) begin
            check("stall_hold", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got 0x%0h expected none", out_data);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", out_data, e.data);
                check("beat_last", out_last, e.last);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wa;
        logic [31:0] wb;
        int          d0;

        vecs[0] = '{1'b1, 32'h44332211, 1'b0, 16'd0, 1'b0, 2, 0, 7'd1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h88776655, 1'b0, 16'd0, 1'b0, 2, 2, 7'd2, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0,        1'b1, 16'd4, 1'b1, 0, 0, 7'd2, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h0,        1'b0, 16'd0, 1'b1, 0, 0, 7'd2, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'h0,        1'b0, 16'd0, 1'b1, 0, 0, 7'd1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 32'h0,        1'b0, 16'd0, 1'b1, 0, 0, 7'd1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h0,        1'b0, 16'd0, 1'b1, 0, 0, 7'd0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 32'h0,        1'b0, 16'd0, 1'b1, 0, 0, 7'd0, 1'b1, 1'b0, 1'b0};

        resetn = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_data = '0;
        start = 1'b0; len = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        resetn = 1'b1;
        tick();

        start = 1'b1; len = 16'd0;
        tick();
        start = 1'b0;
        check("len0_ignored", busy, 0);

        // Basic four-beat feed from two words.
        for (int i = 0; i < 8; i++) begin
            wr_en     = vecs[i].wr;
            wr_data   = vecs[i].data;
            start     = vecs[i].st;
            len       = vecs[i].len;
            out_ready = vecs[i].rdy;
            if (vecs[i].wr) push_word(vecs[i].data, vecs[i].nbeats, vecs[i].last_on);
            tick();
            check($sformatf("vec%0d_level", i), level, vecs[i].e_level);
            check($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_done", i), done, vecs[i].e_done);
        end
        wr_en = 1'b0; start = 1'b0; out_ready = 1'b0;
        check("drained_basic", exp_q.size(), 0);

        // Feed ending mid-word discards the rest of that word.
        write_word(32'h44332211); push_word(32'h44332211, 2, 0);
        write_word(32'h88776655); push_word(32'h88776655, 1, 1);
        start = 1'b1; len = 16'd3; out_ready = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, "done_partial");
        check("partial_level", level, 0);
        check("partial_empty", empty, 1);
        check("drained_partial", exp_q.size(), 0);
        out_ready = 1'b0;
        tick();

        // Backpressure toggling every cycle.
        write_word(32'h44332211); push_word(32'h44332211, 2, 0);
        write_word(32'h88776655); push_word(32'h88776655, 2, 2);
        start = 1'b1; len = 16'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            out_ready = ~out_ready;
            tick();
        end
        check("done_toggle", done, 1);
        check("drained_toggle", exp_q.size(), 0);
        out_ready = 1'b0;
        tick();

        // Fill to full, drop overflow, accept write alongside pop, drain across the wrap.
        for (int i = 0; i < 64; i++) write_word(wd(i));
        check("full_flag", full, 1);
        check("full_level", level, 64);
        write_word(32'hDEADBEEF);
        check("overflow_level", level, 64);
        push_word(wd(0), 2, 2);
        start = 1'b1; len = 16'd2;
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        wr_en = 1'b1; wr_data = wd(64);
        tick();
        wr_en = 1'b0; out_ready = 1'b0;
        check("popwrite_level", level, 64);
        check("popwrite_full", full, 1);
        check("popwrite_done", done, 1);
        tick();
        for (int i = 1; i < 64; i++) push_word(wd(i), 2, 0);
        push_word(wd(64), 2, 2);
        start = 1'b1; len = 16'd128; out_ready = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200, "done_wrap");
        check("wrap_level", level, 0);
        check("wrap_empty", empty, 1);
        check("drained_wrap", exp_q.size(), 0);
        out_ready = 1'b0;
        tick();

        // Underflow stall, resume, then clear mid-feed.
        wa = 32'hA1B2C3D4;
        wb = 32'h5E6F7081;
        write_word(wa); push_word(wa, 2, 0);
        start = 1'b1; len = 16'd8; out_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("stall_valid", out_valid, 0);
        check("stall_busy", busy, 1);
        check("stall_level", level, 0);
        out_ready = 1'b0;
        push_word(wb, 1, 0);
        write_word(wb);
        check("resume_valid", out_valid, 1);
        check("resume_lo", out_data, wb[15:0]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("resume_hi", out_data, wb[31:16]);
        d0 = done_cnt;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_level", level, 0);
        check("clear_empty", empty, 1);
        check("clear_valid", out_valid, 0);
        repeat (3) tick();
        check("clear_no_done", done_cnt, d0);
        check("drained_clear", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
